m8_32_lane_sched: RTL and testbench

- Byte-granular round-robin scheduler that shares one 8b→32b packer among NUM_LANES byte-stream sources.
- Grants one source at a time for exactly one 32-bit word (4 bytes) and forwards its bytes as the packer's data_input/valid_input.
- Pads stalled words to completion and tags each finished word with the lane that produced it.
- Sits between the per-lane byte sources and the 8-32 packer, in the clk_4f domain.

---
 rtl/m8_32_lane_sched_pkg.sv | 19 +
 rtl/m8_32_lane_sched_rr_arbiter.sv | 32 +++
 rtl/m8_32_lane_sched.sv | 191 +++++++++++++++++++
 tb/tb_m8_32_lane_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/m8_32_lane_sched_pkg.sv
// Shared types and constants for the byte-lane scheduler feeding the 8b->32b packer.
// Holds the FSM encoding, word geometry, default pad value and lane-index width helper.
package m8_32_lane_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_PAD  = 2'd2
    } sched_state_t;

    localparam int         WORD_BYTES       = 4;
    localparam logic [7:0] DEFAULT_PAD_BYTE = 8'h00;

    // A single lane still needs a 1-bit index so ports never collapse to zero width.
    function automatic int lane_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/m8_32_lane_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester found searching from i_ptr+1, wrapping.
// Zero latency; no backpressure, the caller decides when the result is used.
module m8_32_lane_sched_rr_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int LW        = 2
) (
    input  logic [NUM_LANES-1:0] i_req,
    input  logic [LW-1:0]        i_ptr,
    output logic [NUM_LANES-1:0] o_grant,
    output logic [LW-1:0]        o_idx,
    output logic                 o_any
);

    logic [LW-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        // The lane at i_ptr itself is visited last, giving it lowest priority.
        for (int k = 1; k <= NUM_LANES; k++) begin
            w_cand = LW'((int'(i_ptr) + k) % NUM_LANES);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/m8_32_lane_sched.sv
// Round-robin scheduler granting one byte lane per 32-bit word to a shared 8b->32b packer.
// One-cycle byte latency; stalled words time out and are padded, back-to-back grants have no bubble.
module m8_32_lane_sched
    import m8_32_lane_sched_pkg::*;
#(
    parameter int         NUM_LANES = 4,
    parameter int         STALL_MAX = 8,
    parameter logic [7:0] PAD_BYTE  = DEFAULT_PAD_BYTE
) (
    input  logic                                clk_4f,
    input  logic                                reset,
    input  logic [NUM_LANES-1:0]                req_in,
    input  logic [NUM_LANES-1:0]                valid_in,
    input  logic [8*NUM_LANES-1:0]              data_in,
    output logic [NUM_LANES-1:0]                ack_out,
    output logic [NUM_LANES-1:0]                grant_out,
    output logic [7:0]                          data_input_o,
    output logic                                valid_input_o,
    output logic                                word_done,
    output logic [lane_idx_w(NUM_LANES)-1:0]    word_lane,
    output logic                                pad_flag
);

    localparam int            LW         = lane_idx_w(NUM_LANES);
    localparam int            SW         = $clog2(STALL_MAX + 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);
    localparam logic [SW-1:0] STALL_SAT  = SW'(STALL_MAX);
    localparam logic [1:0]    LAST_BYTE  = 2'(WORD_BYTES - 1);

    sched_state_t         r_state, w_state_nxt;
    logic [NUM_LANES-1:0] r_grant, w_grant_nxt;
    logic [LW-1:0]        r_gidx, w_gidx_nxt;
    logic [1:0]           r_byte_cnt, w_byte_nxt;
    logic [SW-1:0]        r_stall_cnt, w_stall_nxt;
    logic [LW-1:0]        r_rr_ptr, w_rr_nxt;
    logic [7:0]           r_data, w_data_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_done, w_done_nxt;
    logic [LW-1:0]        r_word_lane, w_lane_nxt;
    logic                 r_pad_flag, w_pad_nxt;

    logic [NUM_LANES-1:0] w_arb_grant;
    logic [LW-1:0]        w_arb_idx;
    logic                 w_arb_any;
    logic [LW-1:0]        w_arb_ptr;
    logic                 w_lane_vld;
    logic [7:0]           w_lane_dat;
    logic                 w_word_end;

    // IDLE resumes rotation from the last finished lane; at word end the current lane is the pointer.
    assign w_arb_ptr = (r_state == ST_IDLE) ? r_rr_ptr : r_gidx;

    m8_32_lane_sched_rr_arbiter #(
        .NUM_LANES (NUM_LANES),
        .LW        (LW)
    ) u_arb (
        .i_req   (req_in),
        .i_ptr   (w_arb_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    assign ack_out    = (r_state == ST_BUSY) ? (r_grant & valid_in) : '0;
    assign w_lane_vld = |ack_out;

    always_comb begin
        w_lane_dat = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (r_grant[i]) begin
                w_lane_dat = data_in[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_byte_nxt  = r_byte_cnt;
        w_stall_nxt = r_stall_cnt;
        w_rr_nxt    = r_rr_ptr;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_lane_nxt  = r_word_lane;
        w_pad_nxt   = 1'b0;
        w_word_end  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_arb_any) begin
                    w_grant_nxt = w_arb_grant;
                    w_gidx_nxt  = w_arb_idx;
                    w_byte_nxt  = '0;
                    w_stall_nxt = '0;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_lane_vld) begin
                    w_data_nxt  = w_lane_dat;
                    w_valid_nxt = 1'b1;
                    w_stall_nxt = '0;
                    if (r_byte_cnt == LAST_BYTE) begin
                        w_word_end = 1'b1;
                    end else begin
                        w_byte_nxt = r_byte_cnt + 2'd1;
                    end
                end else if (r_stall_cnt == STALL_LAST) begin
                    w_stall_nxt = STALL_SAT;
                    if (r_byte_cnt == 2'd0) begin
                        w_grant_nxt = '0;
                        w_rr_nxt    = r_gidx;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_PAD;
                    end
                end else begin
                    w_stall_nxt = r_stall_cnt + SW'(1);
                end
            end
            ST_PAD: begin
                w_data_nxt  = PAD_BYTE;
                w_valid_nxt = 1'b1;
                if (r_byte_cnt == LAST_BYTE) begin
                    w_word_end = 1'b1;
                    w_pad_nxt  = 1'b1;
                end else begin
                    w_byte_nxt = r_byte_cnt + 2'd1;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_word_end) begin
            w_done_nxt  = 1'b1;
            w_lane_nxt  = r_gidx;
            w_rr_nxt    = r_gidx;
            w_byte_nxt  = '0;
            w_stall_nxt = '0;
            if (w_arb_any) begin
                w_grant_nxt = w_arb_grant;
                w_gidx_nxt  = w_arb_idx;
                w_state_nxt = ST_BUSY;
            end else begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_gidx      <= '0;
            r_byte_cnt  <= '0;
            r_stall_cnt <= '0;
            r_rr_ptr    <= LW'(NUM_LANES - 1);
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_word_lane <= '0;
            r_pad_flag  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_gidx      <= w_gidx_nxt;
            r_byte_cnt  <= w_byte_nxt;
            r_stall_cnt <= w_stall_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_done      <= w_done_nxt;
            r_word_lane <= w_lane_nxt;
            r_pad_flag  <= w_pad_nxt;
        end
    end

    assign grant_out     = r_grant;
    assign data_input_o  = r_data;
    assign valid_input_o = r_valid;
    assign word_done     = r_done;
    assign word_lane     = r_word_lane;
    assign pad_flag      = r_pad_flag;

endmodule

// File: tb/tb_m8_32_lane_sched.sv
// Directed bench for the lane scheduler: single words, alternation, padding, empty timeout, mid-word reset.
module tb_m8_32_lane_sched;

    localparam int N = 4;

    logic           clk_4f = 1'b0;
    logic           reset;
    logic [N-1:0]   req_in;
    logic [N-1:0]   valid_in;
    logic [8*N-1:0] data_in;
    logic [N-1:0]   ack_out;
    logic [N-1:0]   grant_out;
    logic [7:0]     data_input_o;
    logic           valid_input_o;
    logic           word_done;
    logic [1:0]     word_lane;
    logic           pad_flag;

    int checks   = 0;
    int failures = 0;
    int exp_lane;
    int acc_idx;
    logic [7:0] exp_dat;

    m8_32_lane_sched #(
        .NUM_LANES (N),
        .STALL_MAX (8),
        .PAD_BYTE  (8'h00)
    ) dut (
        .clk_4f        (clk_4f),
        .reset         (reset),
        .req_in        (req_in),
        .valid_in      (valid_in),
        .data_in       (data_in),
        .ack_out       (ack_out),
        .grant_out     (grant_out),
        .data_input_o  (data_input_o),
        .valid_input_o (valid_input_o),
        .word_done     (word_done),
        .word_lane     (word_lane),
        .pad_flag      (pad_flag)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8*N-1:0] lane_bus(input int lane, input logic [7:0] b);
        logic [8*N-1:0] v;
        v = '0;
        v[8*lane +: 8] = b;
        return v;
    endfunction

    task automatic do_reset();
        reset    = 1'b0;
        req_in   = '0;
        valid_in = '0;
        data_in  = '0;
        @(negedge clk_4f);
        @(negedge clk_4f);
        reset = 1'b1;
    endtask

    // Starts at a negedge with the scheduler idle; sends one full word from a single lane.
    task automatic send_word(input int lane, input logic [31:0] w, input string tag);
        logic [N-1:0] onehot;
        onehot = N'(1) << lane;
        req_in = onehot;
        @(negedge clk_4f);
        chk({tag, "_grant"}, 32'(grant_out), 32'(onehot));
        req_in = '0;
        for (int i = 0; i < 4; i++) begin
            valid_in = onehot;
            data_in  = lane_bus(lane, w[8*i +: 8]);
            #1;
            chk({tag, "_ack"}, 32'(ack_out), 32'(onehot));
            @(negedge clk_4f);
            chk({tag, "_dat"}, 32'(data_input_o), 32'(w[8*i +: 8]));
            chk({tag, "_vld"}, 32'(valid_input_o), 32'd1);
            chk({tag, "_done"}, 32'(word_done), (i == 3) ? 32'd1 : 32'd0);
        end
        chk({tag, "_lane"}, 32'(word_lane), 32'(lane));
        chk({tag, "_pad"}, 32'(pad_flag), 32'd0);
        chk({tag, "_grant_drop"}, 32'(grant_out), 32'd0);
        valid_in = '0;
        data_in  = '0;
        @(negedge clk_4f);
        chk({tag, "_vld_after"}, 32'(valid_input_o), 32'd0);
        chk({tag, "_done_after"}, 32'(word_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        req_in   = '0;
        valid_in = '0;
        data_in  = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_grant", 32'(grant_out), 32'd0);
        chk("rst_vld", 32'(valid_input_o), 32'd0);
        chk("rst_dat", 32'(data_input_o), 32'd0);
        chk("rst_done", 32'(word_done), 32'd0);
        chk("rst_lane", 32'(word_lane), 32'd0);
        chk("rst_pad", 32'(pad_flag), 32'd0);
        chk("rst_ack", 32'(ack_out), 32'd0);
        @(negedge clk_4f);
        @(negedge clk_4f);
        reset = 1'b1;

        // Single word from lane 0.
        send_word(0, 32'h44332211, "t1");

        // Lanes 0 and 2 continuously: words 0,2,0 with no bubble.
        do_reset();
        for (int k = 0; k <= 13; k++) begin
            if (k == 1) chk("t2_grant0", 32'(grant_out), 32'h1);
            if (k == 5) chk("t2_grant2", 32'(grant_out), 32'h4);
            if (k >= 2) begin
                acc_idx  = k - 1;
                exp_lane = (acc_idx >= 5 && acc_idx <= 8) ? 2 : 0;
                exp_dat  = (exp_lane == 2) ? 8'(32 + acc_idx) : 8'(16 + acc_idx);
                chk("t2_dat", 32'(data_input_o), 32'(exp_dat));
                chk("t2_vld", 32'(valid_input_o), 32'd1);
                chk("t2_done", 32'(word_done), (acc_idx % 4 == 0) ? 32'd1 : 32'd0);
                if (acc_idx % 4 == 0) chk("t2_lane", 32'(word_lane), 32'(exp_lane));
            end
            req_in   = 4'b0101;
            valid_in = 4'b0101;
            data_in  = lane_bus(0, 8'(16 + k)) | lane_bus(2, 8'(32 + k));
            @(negedge clk_4f);
        end

        // Lane 1 stalls after two bytes; lane 2 valid while not granted; word padded.
        do_reset();
        req_in = 4'b0010;
        @(negedge clk_4f);
        chk("t3_grant", 32'(grant_out), 32'h2);
        req_in   = '0;
        valid_in = 4'b0010;
        data_in  = lane_bus(1, 8'hAA);
        @(negedge clk_4f);
        chk("t3_datAA", 32'(data_input_o), 32'hAA);
        data_in = lane_bus(1, 8'hBB);
        @(negedge clk_4f);
        chk("t3_datBB", 32'(data_input_o), 32'hBB);
        chk("t3_vldBB", 32'(valid_input_o), 32'd1);
        for (int k = 0; k < 8; k++) begin
            valid_in = 4'b0100;
            data_in  = lane_bus(2, 8'h5A);
            #1;
            chk("t3_ack_other", 32'(ack_out), 32'd0);
            @(negedge clk_4f);
            chk("t3_stall_vld", 32'(valid_input_o), 32'd0);
            chk("t3_stall_grant", 32'(grant_out), 32'h2);
            chk("t3_stall_done", 32'(word_done), 32'd0);
        end
        valid_in = 4'b0010;
        data_in  = lane_bus(1, 8'hEE);
        #1;
        chk("t3_ack_pad", 32'(ack_out), 32'd0);
        @(negedge clk_4f);
        chk("t3_pad1_dat", 32'(data_input_o), 32'h00);
        chk("t3_pad1_vld", 32'(valid_input_o), 32'd1);
        chk("t3_pad1_done", 32'(word_done), 32'd0);
        #1;
        chk("t3_ack_pad2", 32'(ack_out), 32'd0);
        @(negedge clk_4f);
        chk("t3_pad2_dat", 32'(data_input_o), 32'h00);
        chk("t3_pad2_vld", 32'(valid_input_o), 32'd1);
        chk("t3_pad2_done", 32'(word_done), 32'd1);
        chk("t3_pad_flag", 32'(pad_flag), 32'd1);
        chk("t3_lane", 32'(word_lane), 32'd1);
        chk("t3_grant_drop", 32'(grant_out), 32'd0);
        valid_in = '0;
        data_in  = '0;
        @(negedge clk_4f);
        chk("t3_done_clr", 32'(word_done), 32'd0);
        chk("t3_pad_clr", 32'(pad_flag), 32'd0);
        chk("t3_lane_hold", 32'(word_lane), 32'd1);
        chk("t3_vld_clr", 32'(valid_input_o), 32'd0);

        // Lane 3 never sends: grant released after the stall limit, lane 0 granted next.
        do_reset();
        req_in = 4'b1000;
        @(negedge clk_4f);
        chk("t4_grant3", 32'(grant_out), 32'h8);
        req_in = 4'b1001;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk_4f);
            chk("t4_hold_grant", 32'(grant_out), 32'h8);
            chk("t4_hold_vld", 32'(valid_input_o), 32'd0);
            chk("t4_hold_done", 32'(word_done), 32'd0);
        end
        @(negedge clk_4f);
        chk("t4_release", 32'(grant_out), 32'd0);
        chk("t4_rel_vld", 32'(valid_input_o), 32'd0);
        chk("t4_rel_done", 32'(word_done), 32'd0);
        @(negedge clk_4f);
        chk("t4_next_grant", 32'(grant_out), 32'h1);

        // Reset mid-word, then a fresh word completes normally.
        do_reset();
        req_in = 4'b0001;
        @(negedge clk_4f);
        req_in   = '0;
        valid_in = 4'b0001;
        data_in  = lane_bus(0, 8'h01);
        @(negedge clk_4f);
        data_in = lane_bus(0, 8'h02);
        @(negedge clk_4f);
        chk("t5_pre_dat", 32'(data_input_o), 32'h02);
        reset = 1'b0;
        #1;
        chk("t5_rst_grant", 32'(grant_out), 32'd0);
        chk("t5_rst_vld", 32'(valid_input_o), 32'd0);
        chk("t5_rst_dat", 32'(data_input_o), 32'd0);
        chk("t5_rst_ack", 32'(ack_out), 32'd0);
        chk("t5_rst_done", 32'(word_done), 32'd0);
        @(negedge clk_4f);
        reset    = 1'b1;
        valid_in = '0;
        data_in  = '0;
        send_word(0, 32'h34333231, "t5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
